serial_sync_tx: RTL and testbench



---
 rtl/serial_sync_pkg.sv | 21 ++
 rtl/serial_sync_tx_shift_reg.sv | 67 ++++++
 rtl/serial_sync_tx.sv | 139 +++++++++++++
 tb/tb_serial_sync_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sync_pkg.sv
// Shared constants for the serial sync link: FSM state encoding and the
// 7-bit sync preamble that both the transmitter and receivers agree on.
package serial_sync_pkg;

    localparam int SYNC_W = 7;
    localparam logic [SYNC_W-1:0] SYNC_PATTERN = 7'b1101101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        GAP  = 3'd4
    } tx_state_e;

    // Preamble bit idx (0 = first on the wire) of the sync pattern.
    function automatic logic sync_bit(input logic [2:0] idx);
        return SYNC_PATTERN[3'(SYNC_W - 1) - idx];
    endfunction

endpackage

// File: rtl/serial_sync_tx_shift_reg.sv
// Payload shift register: parallel load, MSB-first left shift, and (when
// SERIAL_SYNC_TX_PARITY_EN is defined) a running even-parity accumulator
// over the bits shifted out.
module tx_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              msb_o
`ifdef SERIAL_SYNC_TX_PARITY_EN
    , output logic            parity_o
`endif
);

    logic [DATA_W-1:0] sr_q, sr_d;

    // Load wins over shift; shifting feeds zeros in at the LSB.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = sr_q << 1;
        end
    end

    // Shift register state, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[DATA_W-1];

`ifdef SERIAL_SYNC_TX_PARITY_EN
    logic par_q, par_d;

    // XOR of every bit shifted out since the last load; equals ^payload
    // once all DATA_W bits have gone.
    always_comb begin
        par_d = par_q;
        if (load_i) begin
            par_d = 1'b0;
        end else if (shift_i) begin
            par_d = par_q ^ sr_q[DATA_W-1];
        end
    end

    // Parity accumulator state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign parity_o = par_q;
`endif

endmodule

// File: rtl/serial_sync_tx.sv
// Serial frame transmitter: sync preamble 1101101, payload MSB-first, optional
// even parity bit (build with SERIAL_SYNC_TX_PARITY_EN), then GAP_CYCLES idle
// zeros. The state register names the next bit to drive, so the state reaches
// GAP/IDLE on the edge that puts the last frame bit on out; this is what lets
// GAP_CYCLES=0 run frames back to back.
// Handshake: a payload is accepted at a rising edge where valid_in && ready_out;
// ready_out depends only on the registered state, and the source must hold
// data_in/valid_in until accepted (nothing is buffered).
module serial_sync_tx
    import serial_sync_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              out,
    output logic              busy,
    output logic              frame_done,
    output tx_state_e         state_dbg
);

    localparam int CNT_W = 6;

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load, shift;
    logic             sr_msb;
`ifdef SERIAL_SYNC_TX_PARITY_EN
    logic             sr_par;
`endif

    tx_shift_reg #(.DATA_W(DATA_W)) u_shift_reg (
        .clk     (Clk),
        .rst     (Clr),
        .load_i  (load),
        .shift_i (shift),
        .data_i  (data_in),
        .msb_o   (sr_msb)
`ifdef SERIAL_SYNC_TX_PARITY_EN
        , .parity_o (sr_par)
`endif
    );

    // Next-state, next-bit and handshake decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    load    = 1'b1;
                    out_d   = sync_bit(3'd0);
                    state_d = SYNC;
                    cnt_d   = CNT_W'(1);
                end
            end
            SYNC: begin
                out_d = sync_bit(cnt_q[2:0]);
                if (cnt_q == CNT_W'(SYNC_W - 1)) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                out_d = sr_msb;
                shift = 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_SYNC_TX_PARITY_EN
                    state_d = PAR;
`else
                    done_d  = 1'b1;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
`endif
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SERIAL_SYNC_TX_PARITY_EN
            PAR: begin
                out_d   = sr_par;
                done_d  = 1'b1;
                state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                cnt_d   = '0;
            end
`endif
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM, counter and registered outputs; reset abandons any partial frame.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready_out  = (state_q == IDLE);
    assign out        = out_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_sync_tx.sv
// Directed bench for serial_sync_tx: table of payloads with hand-computed
// frames, plus sequences for scrambled inputs, sync detection, mid-frame
// reset and back-to-back frames (second instance with GAP_CYCLES=0).
module tb_serial_sync_tx;
  import serial_sync_pkg::*;

`ifdef SERIAL_SYNC_TX_PARITY_EN
  localparam int L = 16;
`else
  localparam int L = 15;
`endif

  typedef struct {
    logic [7:0]  data;
    logic [14:0] frame;  // sync + payload, first bit on the wire at [14]
    logic        par;    // even parity of data
  } vec_t;

  // clock / reset
  logic Clk = 1'b0;
  logic Clr;
  always #5 Clk = ~Clk;

  logic [7:0] data_in, data_b;
  logic       valid_in, valid_b;
  logic       ready_out, out, busy, frame_done;
  logic       ready_b, out_b, busy_b, done_b;
  tx_state_e  st, st_b;

  serial_sync_tx #(.DATA_W(8), .GAP_CYCLES(1)) dut (
    .Clk(Clk), .Clr(Clr), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .out(out), .busy(busy), .frame_done(frame_done),
    .state_dbg(st)
  );

  serial_sync_tx #(.DATA_W(8), .GAP_CYCLES(0)) dut_b2b (
    .Clk(Clk), .Clr(Clr), .data_in(data_b), .valid_in(valid_b),
    .ready_out(ready_b), .out(out_b), .busy(busy_b), .frame_done(done_b),
    .state_dbg(st_b)
  );

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  vec_t vec[7];

  // bench-model 1101101 detector on the main line
  logic [6:0] win = 7'd0;
  int det_cnt = 0;
  int det_idx = -1;
  int cur_idx = -1;
  always @(negedge Clk) begin
    win = {win[5:0], out};
    if (win == 7'b1101101) begin
      det_cnt = det_cnt + 1;
      det_idx = cur_idx;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_frame(input logic [14:0] frame, input logic par);
    for (int j = 14; j >= 0; j--) exp_q.push_back(frame[j]);
`ifdef SERIAL_SYNC_TX_PARITY_EN
    exp_q.push_back(par);
`else
    if (par === 1'bx) $display("note: unknown parity entry");
`endif
  endtask

  // driver + compare for one frame on the GAP_CYCLES=1 instance
  task automatic run_frame(input logic [7:0] d, input bit scramble);
    logic [0:0] e;
    check("pre_ready", ready_out, 1);
    check("pre_busy", busy, 0);
    data_in  = d;
    valid_in = 1'b1;
    for (int i = 0; i < L; i++) begin
      tick();
      cur_idx = i;
      if (scramble) begin
        valid_in = 1'($urandom_range(0, 1));
        data_in  = 8'($urandom_range(0, 255));
      end else if (i == 0) begin
        valid_in = 1'b0;
      end
      e = exp_q.pop_front();
      check($sformatf("out_bit%0d", i), out, e);
      check($sformatf("done_bit%0d", i), frame_done, (i == L - 1));
      check($sformatf("busy_bit%0d", i), busy, 1);
      check($sformatf("ready_bit%0d", i), ready_out, 0);
    end
    valid_in = 1'b0;
    tick();
    cur_idx = L;
    check("gap_out", out, 0);
    check("gap_done", frame_done, 0);
    check("gap_ready", ready_out, 1);
    check("gap_busy", busy, 0);
    tick();
    cur_idx = L + 1;
    check("post_out", out, 0);
    check("post_state", 32'(st), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{8'hA5, 15'b110110110100101, 1'b0};
    vec[1] = '{8'h01, 15'b110110100000001, 1'b1};
    vec[2] = '{8'hFF, 15'b110110111111111, 1'b0};
    vec[3] = '{8'h00, 15'b110110100000000, 1'b0};
    vec[4] = '{8'h3C, 15'b110110100111100, 1'b0};
    vec[5] = '{8'h80, 15'b110110110000000, 1'b1};
    vec[6] = '{8'h6D, 15'b110110101101101, 1'b1};

    // reset state
    Clr = 1'b1; data_in = 8'h00; valid_in = 1'b0; data_b = 8'h00; valid_b = 1'b0;
    repeat (3) tick();
    check("rst_out", out, 0);
    check("rst_ready", ready_out, 1);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_state", 32'(st), 32'(IDLE));
    Clr = 1'b0;
    tick();

    // table of payloads
    for (int v = 0; v < 7; v++) begin
      push_frame(vec[v].frame, vec[v].par);
      run_frame(vec[v].data, 1'b0);
    end

    // inputs scrambled while busy: payload is the accepted one, no extra frame
    push_frame(vec[4].frame, vec[4].par);
    run_frame(vec[4].data, 1'b1);
    repeat (3) begin
      tick();
      check("no_extra_out", out, 0);
    end

    // loopback detector with payload 00: one detect on the last sync bit
    repeat (7) tick();
    det_cnt = 0;
    det_idx = -1;
    push_frame(vec[3].frame, vec[3].par);
    run_frame(8'h00, 1'b0);
    repeat (7) tick();
    check("det_count", 32'(det_cnt), 1);
    check("det_index", 32'(det_idx), 6);

    // Clr during DATA bit 10 of an FF frame
    data_in  = 8'hFF;
    valid_in = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      tick();
      if (i == 0) valid_in = 1'b0;
    end
    check("mid_bit10", out, 1);
    check("mid_busy", busy, 1);
    Clr = 1'b1;
    #1;
    check("clr_out", out, 0);
    check("clr_ready", ready_out, 1);
    check("clr_busy", busy, 0);
    check("clr_done", frame_done, 0);
    check("clr_state", 32'(st), 32'(IDLE));
    data_in  = 8'hA5;
    valid_in = 1'b1;
    tick();
    tick();
    check("clr_hold_out", out, 0);
    #2;
    Clr = 1'b0;
    // first edge after release accepts; frame restarts at sync bit 0
    push_frame(vec[0].frame, vec[0].par);
    run_frame(8'hA5, 1'b0);

    // back-to-back frames with GAP_CYCLES=0
    push_frame(vec[2].frame, vec[2].par);
    push_frame(vec[3].frame, vec[3].par);
    check("b2b_pre_ready", ready_b, 1);
    data_b  = 8'hFF;
    valid_b = 1'b1;
    for (int i = 0; i < 2 * L; i++) begin
      logic [0:0] e;
      tick();
      if (i == 0) data_b = 8'h00;
      if (i == L) valid_b = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("b2b_out%0d", i), out_b, e);
      check($sformatf("b2b_done%0d", i), done_b, (i == L - 1) || (i == 2 * L - 1));
      if (i == L - 1) check("b2b_ready_last", ready_b, 1);
      if (i == L) check("b2b_busy_second", busy_b, 1);
    end
    tick();
    check("b2b_end_out", out_b, 0);
    check("b2b_end_ready", ready_b, 1);
    check("b2b_end_done", done_b, 0);
    tick();
    check("b2b_idle_out", out_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
